// File: rtl/vjtag_timer_pkg.sv
// rtl/vjtag_timer_pkg.sv - opcodes, default widths and status bit layout for the vJTAG timer responder
package vjtag_timer_pkg;

  localparam int IR_W_DEF   = 4;
  localparam int DATA_W_DEF = 32;

  localparam logic [31:0] ID_VALUE_DEF = 32'h5449_4D52;

  // Virtual IR opcodes; anything not listed behaves as BYPASS
  localparam int unsigned OP_BYPASS   = 0;
  localparam int unsigned OP_ID       = 1;
  localparam int unsigned OP_TIMER_RD = 2;
  localparam int unsigned OP_CTRL_WR  = 3;
  localparam int unsigned OP_CTRL_RD  = 4;
  localparam int unsigned OP_CLR_STAT = 5;

  // ir_out status layout; bit 3 is a fixed signature so the host can spot a live instance
  localparam int ST_LEN_ERR = 0;
  localparam int ST_WR_DONE = 1;
  localparam int ST_ZERO    = 2;
  localparam int ST_SIG     = 3;

endpackage

// File: rtl/vjtag_timer_responder_if.sv
// rtl/vjtag_timer_responder_if.sv - vJTAG hub to user-logic signal bundle
interface vjtag_timer_responder_if #(
  parameter int IR_W = 4
);
  logic            tdi;
  logic            tdo;
  logic [IR_W-1:0] ir_in;
  logic [IR_W-1:0] ir_out;
  logic            virtual_state_cdr;
  logic            virtual_state_sdr;
  logic            virtual_state_e1dr;
  logic            virtual_state_pdr;
  logic            virtual_state_e2dr;
  logic            virtual_state_udr;
  logic            virtual_state_cir;
  logic            virtual_state_uir;

  // Hub side: drives the decoded TAP and serial input
  modport master (
    output tdi, ir_in,
    output virtual_state_cdr, virtual_state_sdr, virtual_state_e1dr,
    output virtual_state_pdr, virtual_state_e2dr, virtual_state_udr,
    output virtual_state_cir, virtual_state_uir,
    input  tdo, ir_out
  );

  // Responder side
  modport slave (
    input  tdi, ir_in,
    input  virtual_state_cdr, virtual_state_sdr, virtual_state_e1dr,
    input  virtual_state_pdr, virtual_state_e2dr, virtual_state_udr,
    input  virtual_state_cir, virtual_state_uir,
    output tdo, ir_out
  );
endinterface

// File: rtl/vjtag_dr_shifter.sv
// rtl/vjtag_dr_shifter.sv - DATA_W data register with LSB-first shift and saturating bit counter
module vjtag_dr_shifter #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = $clog2(2*DATA_W+1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] load_value,
  input  logic              shift_en,
  input  logic              tdi,
  input  logic              cnt_clr,
  input  logic              cnt_inc,
  output logic [DATA_W-1:0] shift_q,
  output logic [CNT_W-1:0]  bit_cnt
);

  // Saturate well above DATA_W so an over-long scan can never wrap back to a valid length
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(2*DATA_W);

  // Capture beats shift; counter tracks how many bits the host clocked since capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= '0;
      bit_cnt <= '0;
    end else begin
      if (load) begin
        shift_q <= load_value;
      end else if (shift_en) begin
        shift_q <= {tdi, shift_q[DATA_W-1:1]};
      end
      if (cnt_clr) begin
        bit_cnt <= '0;
      end else if (cnt_inc && bit_cnt != CNT_MAX) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/vjtag_timer_responder.sv
// rtl/vjtag_timer_responder.sv - vJTAG user responder: IR decode, DR capture/shift, control commit, status
module vjtag_timer_responder
  import vjtag_timer_pkg::*;
#(
  parameter int                DATA_W   = DATA_W_DEF,
  parameter int                IR_W     = IR_W_DEF,
  parameter logic [DATA_W-1:0] ID_VALUE = DATA_W'(ID_VALUE_DEF)
) (
  input  logic                    tck,
  input  logic                    reset,
  vjtag_timer_responder_if.slave  jtag,
  input  logic [DATA_W-1:0]       timer_value,
  output logic [DATA_W-1:0]       ctrl,
  output logic                    ctrl_stb
);

  localparam int CNT_W = $clog2(2*DATA_W+1);

  logic              is_id, is_timer, is_ctrl_wr, is_ctrl_rd, is_clr, data_ir;
  logic [DATA_W-1:0] cap_value;
  logic              cap_act, shift_act, upd_act, dr_hold;
  logic              commit, len_bad, clr_act;
  logic              bypass_q, wr_done, len_err;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IR_W-1:0]   status;

  // Opcode decode and capture source; unknown codes fall through to bypass
  always_comb begin
    is_id      = (jtag.ir_in == IR_W'(OP_ID));
    is_timer   = (jtag.ir_in == IR_W'(OP_TIMER_RD));
    is_ctrl_wr = (jtag.ir_in == IR_W'(OP_CTRL_WR));
    is_ctrl_rd = (jtag.ir_in == IR_W'(OP_CTRL_RD));
    is_clr     = (jtag.ir_in == IR_W'(OP_CLR_STAT));
    data_ir    = is_id | is_timer | is_ctrl_wr | is_ctrl_rd;
    cap_value  = ctrl;
    if (is_id) begin
      cap_value = ID_VALUE;
    end else if (is_timer) begin
      cap_value = timer_value;
    end
  end

  // TAP action qualification: cdr > sdr > udr, and pause-path states freeze everything
  always_comb begin
    dr_hold   = jtag.virtual_state_e1dr | jtag.virtual_state_pdr | jtag.virtual_state_e2dr;
    cap_act   = jtag.virtual_state_cdr;
    shift_act = jtag.virtual_state_sdr & ~cap_act & ~dr_hold;
    upd_act   = jtag.virtual_state_udr & ~cap_act & ~jtag.virtual_state_sdr & ~dr_hold;
    commit    = upd_act & is_ctrl_wr & (bit_cnt == CNT_W'(DATA_W));
    len_bad   = upd_act & is_ctrl_wr & (bit_cnt != CNT_W'(DATA_W));
    clr_act   = jtag.virtual_state_uir & is_clr;
  end

  vjtag_dr_shifter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_shifter (
    .clk        (tck),
    .rst        (reset),
    .load       (cap_act & data_ir),
    .load_value (cap_value),
    .shift_en   (shift_act & data_ir),
    .tdi        (jtag.tdi),
    .cnt_clr    (cap_act),
    .cnt_inc    (shift_act),
    .shift_q    (shift_q),
    .bit_cnt    (bit_cnt)
  );

  assign jtag.tdo = data_ir ? shift_q[0] : bypass_q;

  // Status word in the ir_out bit layout
  always_comb begin
    status             = '0;
    status[ST_SIG]     = 1'b1;
    status[ST_ZERO]    = 1'b0;
    status[ST_WR_DONE] = wr_done;
    status[ST_LEN_ERR] = len_err;
  end

  // Bypass bit, control commit, sticky status (set beats clear) and registered ir_out
  always_ff @(posedge tck or posedge reset) begin
    if (reset) begin
      bypass_q    <= 1'b0;
      ctrl        <= '0;
      ctrl_stb    <= 1'b0;
      wr_done     <= 1'b0;
      len_err     <= 1'b0;
      jtag.ir_out <= IR_W'(4'b1000);
    end else begin
      if (cap_act && !data_ir) begin
        bypass_q <= 1'b0;
      end else if (shift_act && !data_ir) begin
        bypass_q <= jtag.tdi;
      end
      ctrl_stb <= commit;
      if (commit) begin
        ctrl <= shift_q;
      end
      if (commit) begin
        wr_done <= 1'b1;
      end else if (clr_act) begin
        wr_done <= 1'b0;
      end
      if (len_bad) begin
        len_err <= 1'b1;
      end else if (clr_act) begin
        len_err <= 1'b0;
      end
      jtag.ir_out <= status;
    end
  end

endmodule
